// File: rtl/elevator_scan_controller_pkg.sv
// Shared types for the SCAN elevator controller.
// Holds FSM state encoding and default sizing parameters.
package elevator_scan_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_e;

  localparam int DEF_N_FLOORS    = 4;
  localparam int DEF_FLOOR_W     = 2;
  localparam int DEF_DOOR_CYCLES = 8;

endpackage

// File: rtl/elevator_scan_controller_door_timer.sv
// Door hold timer: load reloads to CYCLES-1, en counts down to 0.
// Ports: clk, reset (async high), load, en in; done out (count is 0).
module elevator_scan_controller_door_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(CYCLES - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN elevator controller: pending-call bitmap, floor tracking, motor/door FSM.
// Ports: clk, reset, req_valid/req_floor, floor_tick in; floor, motors, door, served, pending, sensor_err out.
module elevator_scan_controller
  import elevator_scan_controller_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  input  logic                floor_tick,
  output logic [FLOOR_W-1:0]  actual_floor,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic                served,
  output logic [N_FLOORS-1:0] pending,
  output logic                sensor_err
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

  state_e state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic                dir_up_q, dir_up_d;
  logic                sensor_err_q, sensor_err_d;
  logic                served_q, served_d;

  logic [FLOOR_W-1:0]  floor_up, floor_dn;
  logic [N_FLOORS-1:0] req_hot, cur_hot, up_hot, dn_hot;
  logic [N_FLOORS-1:0] above, below;
  logic [N_FLOORS-1:0] set_hot, clr_hot;
  logic                tmr_load, tmr_done;

  assign floor_up = floor_q + FLOOR_W'(1);
  assign floor_dn = floor_q - FLOOR_W'(1);

  // One-hot decodes; out-of-range request floors match no bit.
  always_comb begin
    req_hot = '0;
    cur_hot = '0;
    up_hot  = '0;
    dn_hot  = '0;
    above   = '0;
    below   = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      req_hot[i] = req_valid && (req_floor == FLOOR_W'(i));
      cur_hot[i] = (floor_q == FLOOR_W'(i));
      up_hot[i]  = (floor_up == FLOOR_W'(i));
      dn_hot[i]  = (floor_dn == FLOOR_W'(i));
      above[i]   = pending_q[i] && (FLOOR_W'(i) > floor_q);
      below[i]   = pending_q[i] && (FLOOR_W'(i) < floor_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    sensor_err_d = sensor_err_q;
    served_d     = 1'b0;
    tmr_load     = 1'b0;
    clr_hot      = '0;
    set_hot      = req_hot;

    unique case (state_q)
      S_IDLE: begin
        if (floor_tick) begin
          sensor_err_d = 1'b1;
        end
        if (|(pending_q & cur_hot)) begin
          state_d  = S_DOOR_OPEN;
          clr_hot  = cur_hot;
          served_d = 1'b1;
          tmr_load = 1'b1;
        end else if ((|above) && (|below)) begin
          state_d = dir_up_q ? S_MOVE_UP : S_MOVE_DOWN;
        end else if (|above) begin
          state_d  = S_MOVE_UP;
          dir_up_d = 1'b1;
        end else if (|below) begin
          state_d  = S_MOVE_DOWN;
          dir_up_d = 1'b0;
        end
      end

      S_MOVE_UP: begin
        if (floor_tick) begin
          if (floor_q == TOP_FLOOR) begin
            sensor_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            floor_d = floor_up;
            // A call for the arrival floor in the same cycle is
            // absorbed by this stop rather than left pending.
            if (|((pending_q | req_hot) & up_hot)) begin
              state_d  = S_DOOR_OPEN;
              clr_hot  = up_hot;
              served_d = 1'b1;
              tmr_load = 1'b1;
            end
          end
        end
      end

      S_MOVE_DOWN: begin
        if (floor_tick) begin
          if (floor_q == '0) begin
            sensor_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            floor_d = floor_dn;
            if (|((pending_q | req_hot) & dn_hot)) begin
              state_d  = S_DOOR_OPEN;
              clr_hot  = dn_hot;
              served_d = 1'b1;
              tmr_load = 1'b1;
            end
          end
        end
      end

      S_DOOR_OPEN: begin
        if (floor_tick) begin
          sensor_err_d = 1'b1;
        end
        // A call for the open floor holds the door instead of latching.
        set_hot = req_hot & ~cur_hot;
        if (|(req_hot & cur_hot)) begin
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_d = S_IDLE;
        end
      end
    endcase

    pending_d = (pending_q | set_hot) & ~clr_hot;
  end

  elevator_scan_controller_door_timer #(
    .CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .en   (state_q == S_DOOR_OPEN),
    .done (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      floor_q      <= '0;
      pending_q    <= '0;
      dir_up_q     <= 1'b1;
      sensor_err_q <= 1'b0;
      served_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      pending_q    <= pending_d;
      dir_up_q     <= dir_up_d;
      sensor_err_q <= sensor_err_d;
      served_q     <= served_d;
    end
  end

  assign actual_floor = floor_q;
  assign motor_up     = (state_q == S_MOVE_UP);
  assign motor_down   = (state_q == S_MOVE_DOWN);
  assign door_open    = (state_q == S_DOOR_OPEN);
  assign served       = served_q;
  assign pending      = pending_q;
  assign sensor_err   = sensor_err_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: vector table plus corner sequences.
// Ports driven directly; outputs sampled 1ns after each rising edge.
module tb_elevator_scan_controller;

  localparam int NF = 4;
  localparam int FW = 3;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          floor_tick = 1'b0;
  logic [FW-1:0] actual_floor;
  logic          motor_up, motor_down, door_open, served;
  logic [NF-1:0] pending;
  logic          sensor_err;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  elevator_scan_controller #(
    .N_FLOORS   (NF),
    .FLOOR_W    (FW),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .floor_tick  (floor_tick),
    .actual_floor(actual_floor),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .door_open   (door_open),
    .served      (served),
    .pending     (pending),
    .sensor_err  (sensor_err)
  );

  typedef struct {
    logic          rst;
    logic          rv;
    logic [FW-1:0] rf;
    logic          tk;
    logic [FW-1:0] fl;
    logic          up;
    logic          dn;
    logic          door;
    logic          srv;
    logic [NF-1:0] pend;
    logic          err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic rst, logic rv, logic [FW-1:0] rf, logic tk,
    logic [FW-1:0] fl, logic up, logic dn, logic door,
    logic srv, logic [NF-1:0] pend, logic err);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rf = rf; v.tk = tk;
    v.fl = fl; v.up = up; v.dn = dn; v.door = door;
    v.srv = srv; v.pend = pend; v.err = err;
    return v;
  endfunction

  function automatic logic [11:0] obs();
    return {actual_floor, motor_up, motor_down,
            door_open, served, pending, sensor_err};
  endfunction

  task automatic check(input string name,
                       input logic [11:0] got,
                       input logic [11:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got fl/up/dn/door/srv/pend/err=%b want %b",
               name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, exp);
  endtask

  task automatic expect_o(input string name,
                          input logic [FW-1:0] fl,
                          input logic up, input logic dn,
                          input logic door, input logic srv,
                          input logic [NF-1:0] pend, input logic err);
    check(name, obs(), {fl, up, dn, door, srv, pend, err});
  endtask

  task automatic cyc(input logic r, input logic rv,
                     input logic [FW-1:0] rf, input logic tk);
    reset = r;
    req_valid = rv;
    req_floor = rf;
    floor_tick = tk;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    floor_tick = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int srv_cnt;
    int drop;
    int d;

    // Reset, call to floor 2, travel up and hold the door.
    vq.push_back(mk(1,0,0,0, 0,0,0,0,0,4'b0000,0));
    vq.push_back(mk(0,1,2,0, 0,0,0,0,0,4'b0100,0));
    vq.push_back(mk(0,0,0,0, 0,1,0,0,0,4'b0100,0));
    vq.push_back(mk(0,0,0,1, 1,1,0,0,0,4'b0100,0));
    vq.push_back(mk(0,0,0,0, 1,1,0,0,0,4'b0100,0));
    vq.push_back(mk(0,0,0,1, 2,0,0,1,1,4'b0000,0));
    repeat (7) vq.push_back(mk(0,0,0,0, 2,0,0,1,0,4'b0000,0));
    vq.push_back(mk(0,0,0,0, 2,0,0,0,0,4'b0000,0));
    // Up to 3, then calls at 1 and 0 served going down.
    vq.push_back(mk(0,1,3,0, 2,0,0,0,0,4'b1000,0));
    vq.push_back(mk(0,0,0,0, 2,1,0,0,0,4'b1000,0));
    vq.push_back(mk(0,0,0,1, 3,0,0,1,1,4'b0000,0));
    vq.push_back(mk(0,1,1,0, 3,0,0,1,0,4'b0010,0));
    vq.push_back(mk(0,1,0,0, 3,0,0,1,0,4'b0011,0));
    repeat (5) vq.push_back(mk(0,0,0,0, 3,0,0,1,0,4'b0011,0));
    vq.push_back(mk(0,0,0,0, 3,0,0,0,0,4'b0011,0));
    vq.push_back(mk(0,0,0,0, 3,0,1,0,0,4'b0011,0));
    vq.push_back(mk(0,0,0,1, 2,0,1,0,0,4'b0011,0));
    vq.push_back(mk(0,0,0,1, 1,0,0,1,1,4'b0001,0));
    repeat (7) vq.push_back(mk(0,0,0,0, 1,0,0,1,0,4'b0001,0));
    vq.push_back(mk(0,0,0,0, 1,0,0,0,0,4'b0001,0));
    vq.push_back(mk(0,0,0,0, 1,0,1,0,0,4'b0001,0));
    vq.push_back(mk(0,0,0,1, 0,0,0,1,1,4'b0000,0));
    repeat (7) vq.push_back(mk(0,0,0,0, 0,0,0,1,0,4'b0000,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,0,4'b0000,0));

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].rv, vq[i].rf, vq[i].tk);
      check($sformatf("vec%0d", i), obs(),
            {vq[i].fl, vq[i].up, vq[i].dn, vq[i].door,
             vq[i].srv, vq[i].pend, vq[i].err});
    end

    // SCAN order: heading to 3, call at 0 waits until 3 is served.
    cyc(0,1,3,0);
    expect_o("t3_req3", 0,0,0,0,0,4'b1000,0);
    cyc(0,0,0,0);
    expect_o("t3_go_up", 0,1,0,0,0,4'b1000,0);
    cyc(0,0,0,1);
    cyc(0,1,0,0);
    expect_o("t3_req0_mid", 1,1,0,0,0,4'b1001,0);
    cyc(0,0,0,1);
    expect_o("t3_pass2", 2,1,0,0,0,4'b1001,0);
    cyc(0,0,0,1);
    expect_o("t3_serve3", 3,0,0,1,1,4'b0001,0);
    repeat (8) cyc(0,0,0,0);
    expect_o("t3_idle3", 3,0,0,0,0,4'b0001,0);
    cyc(0,0,0,0);
    expect_o("t3_reverse", 3,0,1,0,0,4'b0001,0);
    cyc(0,0,0,1);
    cyc(0,0,0,1);
    cyc(0,0,0,1);
    expect_o("t3_serve0", 0,0,0,1,1,4'b0000,0);
    repeat (8) cyc(0,0,0,0);
    expect_o("t3_idle0", 0,0,0,0,0,4'b0000,0);

    // Door held open by repeated calls for the open floor.
    cyc(0,1,2,0);
    cyc(0,0,0,0);
    cyc(0,0,0,1);
    cyc(0,0,0,1);
    expect_o("t4_arrive2", 2,0,0,1,1,4'b0000,0);
    srv_cnt = 1;
    drop = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin
        cyc(0,0,0,0);
        srv_cnt += int'(served);
        if (!door_open) drop++;
      end
      cyc(0,1,2,0);
      srv_cnt += int'(served);
      expect_o($sformatf("t4_hold%0d", k), 2,0,0,1,0,4'b0000,0);
    end
    d = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0,0,0,0);
      srv_cnt += int'(served);
      if (!door_open) break;
      d++;
    end
    check_int("t4_door_drop", drop, 0);
    check_int("t4_tail_cycles", d, DC - 1);
    check_int("t4_served_once", srv_cnt, 1);

    // Sensor tick while idle; out-of-range calls.
    cyc(0,0,0,1);
    expect_o("t5_tick_idle", 2,0,0,0,0,4'b0000,1);
    cyc(0,1,5,0);
    expect_o("t5_req5", 2,0,0,0,0,4'b0000,1);
    cyc(0,1,4,0);
    cyc(0,0,0,0);
    expect_o("t5_req4", 2,0,0,0,0,4'b0000,1);

    // Asynchronous reset in the middle of an upward move.
    cyc(1,0,0,0);
    expect_o("t6_reset", 0,0,0,0,0,4'b0000,0);
    cyc(0,1,3,0);
    cyc(0,0,0,0);
    cyc(0,0,0,1);
    expect_o("t6_moving", 1,1,0,0,0,4'b1000,0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_o("t6_async", 0,0,0,0,0,4'b0000,0);
    cyc(0,0,0,0);
    cyc(0,0,0,0);
    expect_o("t6_after", 0,0,0,0,0,4'b0000,0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
